layer_stream_serializer: RTL

Converts the packed parallel output vector of one fully-connected layer (NUM_IN values of dataWidth bits) into a one-value-per-cycle stream for the next streaming layer. Applies optional ReLU and tracks the running argmax, which gives the classification result after the last layer. Sits between a layer's packed `out` bus and the next layer's `myinput` input. The next layer's `pause` input is driven from `~out_valid | ~out_ready`.

---
 rtl/layer_stream_serializer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/layer_stream_serializer.sv
// ---------------------------------------------------------------------------
// layer_stream_serializer
//
// Turns the packed parallel result of one fully-connected layer into a
// one-value-per-cycle stream for the next streaming layer. Negative values
// are optionally clamped to zero at capture (RELU), and the running argmax
// of the streamed values gives the classification result after the last
// layer.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for in_valid; in_ready=1, captures the whole vector
// STREAM | presenting buf[idx]; advances on out_valid & out_ready
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready packed vector handshake (in_ready high only in IDLE)
//   in_data           NUM_IN values, element i at [dataWidth*i +: dataWidth]
//   out_data/out_valid/out_ready/out_last  element stream, last on NUM_IN-1
//   out_argmax/out_max  index/value of the largest element of the last
//                       completed vector (ties keep the lowest index)
//   argmax_valid      one-cycle pulse when out_argmax/out_max update
// ---------------------------------------------------------------------------
module layer_stream_serializer #(
    parameter int NUM_IN    = 10,
    parameter int dataWidth = 16,
    parameter int frac_bits = 11,
    parameter bit RELU      = 1'b1,
    parameter int IDXW      = $clog2(NUM_IN)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    input  logic [NUM_IN*dataWidth-1:0] in_data,
    output logic                        in_ready,
    output logic [dataWidth-1:0]        out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_last,
    output logic [IDXW-1:0]             out_argmax,
    output logic [dataWidth-1:0]        out_max,
    output logic                        argmax_valid
);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    // frac_bits only documents the fixed-point format; values are compared
    // as plain signed integers, so nothing below depends on it.
    if (frac_bits > dataWidth) begin : g_frac_bits_unchecked
    end

    state_t                       r_state;
    state_t                       w_state_nxt;
    logic signed [dataWidth-1:0]  r_buf [NUM_IN];
    logic signed [dataWidth-1:0]  w_cap [NUM_IN];
    logic [IDXW-1:0]              r_idx;
    logic signed [dataWidth-1:0]  r_run_max;
    logic [IDXW-1:0]              r_run_idx;
    logic signed [dataWidth-1:0]  r_max;
    logic [IDXW-1:0]              r_argmax;
    logic                         r_argmax_valid;

    logic signed [dataWidth-1:0]  w_cur;
    logic                         w_last_idx;
    logic                         w_beat;
    logic                         w_capture;
    logic                         w_greater;

    assign w_cur      = r_buf[r_idx];
    assign w_last_idx = (r_idx == IDXW'(NUM_IN - 1));
    assign w_beat     = (r_state == S_STREAM) && out_ready;
    assign w_capture  = (r_state == S_IDLE) && in_valid;
    // Strictly greater, so equal values keep the earlier (lower) index.
    assign w_greater  = (w_cur > r_run_max);

    always_comb begin
        for (int i = 0; i < NUM_IN; i++) begin
            w_cap[i] = in_data[dataWidth*i +: dataWidth];
            if (RELU && w_cap[i][dataWidth-1]) begin
                w_cap[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        out_last    = 1'b0;
        out_data    = '0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                out_valid = 1'b1;
                out_data  = w_cur;
                out_last  = w_last_idx;
                if (out_ready && w_last_idx) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_IN; i++) begin
                r_buf[i] <= '0;
            end
            r_idx          <= '0;
            r_run_max      <= '0;
            r_run_idx      <= '0;
            r_max          <= '0;
            r_argmax       <= '0;
            r_argmax_valid <= 1'b0;
        end else begin
            r_argmax_valid <= 1'b0;
            if (w_capture) begin
                r_buf     <= w_cap;
                r_idx     <= '0;
                r_run_max <= w_cap[0];
                r_run_idx <= '0;
            end else if (w_beat) begin
                if (w_greater) begin
                    r_run_max <= w_cur;
                    r_run_idx <= r_idx;
                end
                if (w_last_idx) begin
                    // Result must include the comparison of the last beat.
                    r_max          <= w_greater ? w_cur : r_run_max;
                    r_argmax       <= w_greater ? r_idx : r_run_idx;
                    r_argmax_valid <= 1'b1;
                end else begin
                    r_idx <= r_idx + 1'b1;
                end
            end
        end
    end

    assign out_argmax   = r_argmax;
    assign out_max      = r_max;
    assign argmax_valid = r_argmax_valid;

endmodule
